// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract engine.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Bit-counter width; usable in localparam declarations.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa_dec_slice.sv
// Combinational 1-bit full adder, with both outputs ORed from a 3-to-8 minterm decoder.
module fa_dec_slice (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic [7:0] dec;

  always_comb begin
    dec = '0;
    dec[{x, y, ci}] = 1'b1;
  end

  assign s  = dec[1] | dec[2] | dec[4] | dec[7];
  assign co = dec[3] | dec[5] | dec[6] | dec[7];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract engine: one full-adder slice sequenced LSB-first over WIDTH clocks.
// Optional OVERFLOW_FLAG_EN adds a signed-overflow output ovf.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             sub_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             fa_s, fa_co;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 comes from carry preset at start.
  fa_dec_slice u_slice (
    .x  (a_sh[0]),
    .y  (b_sh[0] ^ sub_q),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Operand shift registers: loaded on an accepted start, shifted once per processed bit.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && !rst) begin
      a_sh  <= a;
      b_sh  <= b;
      sub_q <= sub;
    end else if (state == S_RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            carry  <= sub;
            cnt    <= '0;
            result <= '0;
`ifdef OVERFLOW_FLAG_EN
            ovf    <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          result[cnt] <= fa_s;
          carry       <= fa_co;
          cnt         <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            cout <= fa_co;
`ifdef OVERFLOW_FLAG_EN
            // carry still holds the carry into the MSB; fa_co is the carry out of it.
            ovf  <= carry ^ fa_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and randomized bench for serial_addsub_ctrl against an arithmetic reference model.
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to completion; intrude>=0 pulses a foreign start
  // during the cycle in which bit index 'intrude' is being processed.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input int intrude);
    int ai, bi, r, sa, sb, sr, mask;
    logic [W-1:0] exp_res;
    logic exp_cout, exp_ovf;
    ai = int'(xa);
    bi = int'(xb);
    r  = xs ? ai - bi : ai + bi;
    exp_res  = W'(r & ((1 << W) - 1));
    exp_cout = xs ? (ai >= bi) : (r >= (1 << W));
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    sr = xs ? sa - sb : sa + sb;
    exp_ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));

    a = xa; b = xb; sub = xs; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 1; k <= W; k++) begin
      if (k - 1 == intrude) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0;
      end
      step();
      start = 1'b0;
      mask = (1 << k) - 1;
      check("partial_result", 32'(result), 32'(int'(exp_res) & mask));
      check("done_timing", 32'(done), 32'(k == W));
    end
    check("result", 32'(result), 32'(exp_res));
    check("cout", 32'(cout), 32'(exp_cout));
    check("busy_in_done", 32'(busy), 32'd1);
`ifdef OVERFLOW_FLAG_EN
    check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    step();
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(exp_res));
  endtask

  initial begin
    int saw_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op(8'd100, 8'd27, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    run_op(8'h00, 8'h00, 1'b0, -1);
    run_op(8'd7, 8'd5, 1'b1, -1);
    run_op(8'd5, 8'd7, 1'b1, -1);

    // Start pulsed mid-run must be ignored, and must not spawn a second request.
    run_op(8'h10, 8'h01, 1'b0, 4);
    step();
    check("ignored_start_busy", 32'(busy), 32'd0);

    // Reset at RUN bit 3 after a request that left cout=1.
    run_op(8'hF0, 8'h20, 1'b0, -1);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) saw_done = 1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(8'd3, 8'd4, 1'b0, -1);

    // Reset and start together: reset wins.
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    step();
    check("rst_start_busy2", 32'(busy), 32'd0);

    // Signed-overflow vectors.
    run_op(8'd100, 8'd100, 1'b0, -1);
    run_op(8'd50, 8'd20, 1'b0, -1);
    run_op(8'h80, 8'h01, 1'b1, -1);

    for (int n = 0; n < 25; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
